mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Upstream stage that drives the select lines (s0, s1) of the 4-to-1 mux.
- Steps through the enabled channels in ascending order. For each channel it holds the select for a settle interval, then a programmable dwell.
- At the end of each dwell it emits a one-cycle sample strobe tagged with the channel number, so a downstream capture knows when the mux output is valid.
- Supports a single sweep or continuous scanning.

Parameters:
- DWELL_W, 4, width of the dwell count input.
- SETTLE_CYCLES, 1, cycles the select is held before dwell counting begins (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- stop  in  1  request termination after the current channel's sample.
- mode  in  1  0 = single sweep, 1 = continuous.
- ch_mask  in  4  channel enables; bit n enables input n.
- dwell  in  DWELL_W  dwell cycles per channel; 0 is treated as 1.
- s0  out  1  mux select LSB.
- s1  out  1  mux select MSB.
- sample_en  out  1  one-cycle strobe: mux output is valid for ch_id.
- ch_id  out  2  channel currently selected, equal to {s1,s0}.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan ends.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: s0=0, s1=0, ch_id=0, sample_en=0, busy=0, done=0. State is IDLE and stop_pending is cleared.
- States: IDLE, SETTLE, DWELL.
- IDLE:
  - start=1 with ch_mask!=0: latch ch_mask, dwell and mode. Drive {s1,s0} and ch_id to the lowest enabled channel. Set busy=1, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - start=1 with ch_mask=0: done=1 for one cycle, busy stays 0, state stays IDLE.
  - Otherwise outputs hold their last values.
- SETTLE:
  - Counts SETTLE_CYCLES cycles.
  - Then loads the dwell counter with max(dwell_latched,1) and goes to DWELL.
- DWELL:
  - Counts the dwell cycles. sample_en=1 during the final dwell cycle only.
  - At the edge that ends the sample_en cycle, the next enabled channel is selected: ascending from the current channel, wrapping from 3 to 0.
  - Single mode, wrap past the highest enabled channel: go to IDLE, set busy=0, and pulse done=1 in the following cycle.
  - Continuous mode: the wrap continues into SETTLE on the lowest enabled channel.
  - Select changes take effect only at this edge, never mid-dwell.
- Latency: with start sampled at edge E0, the select is valid from E0. sample_en is high in cycle SETTLE_CYCLES+dwell after E0 (the first cycle after E0 counts as cycle 1).
- Single enabled channel:
  - Single mode: one sample, then done.
  - Continuous mode: the same channel is resampled, with SETTLE repeated each pass.
- stop:
  - Asserted while busy, for any cycle, sets stop_pending.
  - The scan ends after the next sample_en: IDLE, busy=0, done pulse, select held. Single mode ends the same way.
  - stop in IDLE is ignored. stop and start in the same IDLE cycle: start wins, and stop is ignored.
- start while busy is ignored. Changes to ch_mask, dwell or mode while busy are ignored until the next start.
- done and sample_en are never high in the same cycle.
- Reset mid-scan: immediate return to reset values, with no done pulse.

Decomposition:
- Shared package mux_seq_pkg:
  - state encoding localparams: IDLE=2'd0, SETTLE=2'd1, DWELL=2'd2;
  - NUM_CH=4;
  - SEL_W=2.
- One sub-module, mux_next_channel: combinational.
  - Inputs: current channel and latched mask.
  - Outputs: next enabled channel and a wrapped flag.
  - Reused to pick the first channel from IDLE by presenting current channel = 3.

Test Plan:
1. rst pulsed asynchronously mid-cycle -> all outputs read 0 immediately, independent of clk.
2. ch_mask=4'b1111, dwell=2, mode=0, SETTLE_CYCLES=1, start pulse -> ch_id sequence 0,1,2,3. sample_en in cycles 3, 6, 9, 12 after the start edge. done pulse in cycle 13. busy low in cycle 13.
3. ch_mask=4'b1010, dwell=0, mode=1 -> select alternates 1,3,1,3. sample_en every 2 cycles. stop asserted during channel 3's settle -> sample on ch 3, then done, IDLE, select held at 3.
4. start with ch_mask=0 -> done pulse next cycle, busy never asserts, no sample_en.
5. Mid-scan, ch_mask changed to 4'b0001 and start re-pulsed -> no effect; the original sweep completes on its latched mask.
6. rst asserted during DWELL of channel 2 -> outputs return to reset values, no sample_en, no done. A new start then begins cleanly from the lowest enabled channel.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: state encoding,
// channel count and select width.
package mux_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // State encoding values, also usable by checkers bound to the FSM.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DWELL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETTLE = SETTLE,
        ST_DWELL  = DWELL
    } state_t;

    // Presenting the highest channel as "current" makes the next-channel
    // search return the lowest enabled channel.
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux_next_channel.sv
// Combinational successor search: returns the next enabled channel above
// cur_ch, wrapping from the top channel back to 0. wrapped is set when the
// search had to pass channel NUM_CH-1 (or landed back on cur_ch itself).
// With an empty mask next_ch echoes cur_ch and wrapped is set.
module mux_next_channel
    import mux_seq_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_ch,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next_ch,
    output logic              wrapped
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Scan offsets 1..NUM_CH from the current channel; first enabled hit wins.
    always_comb begin
        next_ch = cur_ch;
        wrapped = 1'b1;
        found   = 1'b0;
        idx     = cur_ch;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = cur_ch + SEL_W'(off);
            if (!found && mask[idx]) begin
                found   = 1'b1;
                next_ch = idx;
                wrapped = (int'(cur_ch) + off) >= NUM_CH;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives the select lines of a 4-to-1 mux. Walks the latched channel mask in
// ascending order; each channel is held for SETTLE_CYCLES, then for the
// latched dwell, and the last dwell cycle carries a one-cycle sample strobe
// tagged by ch_id. Single-sweep or continuous scanning, with a sticky stop
// request that ends the scan after the next sample.
//
// Control handshake: start is a level sampled only while idle (busy=0);
// stop is a level sampled only while busy and remembered until the next
// sample. sample_en and done are single-cycle strobes with no back-pressure:
// the consumer must take them in the cycle they are high.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL_W       = 4,
    parameter int SETTLE_CYCLES = 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               sample_en,
    output logic [SEL_W-1:0]   ch_id,
    output logic               busy,
    output logic               done
);

    localparam int               SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

    state_t               state;
    logic [NUM_CH-1:0]    mask_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic                 mode_q;
    logic                 stop_pending;
    logic [SET_W-1:0]     settle_cnt;
    logic [DWELL_W-1:0]   dwell_cnt;

    logic [SEL_W-1:0]     nc_cur;
    logic [NUM_CH-1:0]    nc_mask;
    logic [SEL_W-1:0]     nc_next;
    logic                 nc_wrapped;
    logic [DWELL_W-1:0]   dwell_load;
    logic                 end_scan;

    // Idle: find the first channel of the incoming mask. Busy: successor of
    // the current channel within the latched mask.
    always_comb begin
        if (state == ST_IDLE) begin
            nc_cur  = LAST_CH;
            nc_mask = ch_mask;
        end else begin
            nc_cur  = ch_id;
            nc_mask = mask_q;
        end
    end

    mux_next_channel u_next (
        .cur_ch  (nc_cur),
        .mask    (nc_mask),
        .next_ch (nc_next),
        .wrapped (nc_wrapped)
    );

    // A zero dwell still gives one cycle so every channel gets a sample.
    assign dwell_load = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

    // Evaluated at the edge closing a sample cycle: a stop seen on that very
    // edge counts, as does a single sweep passing its highest channel.
    assign end_scan = stop_pending | stop | (~mode_q & nc_wrapped);

    // Sequencer FSM with registered select, strobe and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            s0           <= 1'b0;
            s1           <= 1'b0;
            ch_id        <= '0;
            sample_en    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mask_q       <= '0;
            dwell_q      <= '0;
            mode_q       <= 1'b0;
            stop_pending <= 1'b0;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
        end else begin
            sample_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (ch_mask != '0) begin
                            mask_q       <= ch_mask;
                            dwell_q      <= dwell;
                            mode_q       <= mode;
                            ch_id        <= nc_next;
                            s0           <= nc_next[0];
                            s1           <= nc_next[1];
                            busy         <= 1'b1;
                            settle_cnt   <= SETTLE_LOAD;
                            stop_pending <= 1'b0;
                            state        <= ST_SETTLE;
                        end else begin
                            // Nothing to scan: report completion at once.
                            done <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (settle_cnt == SET_W'(1)) begin
                        dwell_cnt <= dwell_load;
                        // A one-cycle dwell is its own sample cycle.
                        sample_en <= (dwell_load == DWELL_W'(1));
                        state     <= ST_DWELL;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                ST_DWELL: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (dwell_cnt == DWELL_W'(1)) begin
                        // This edge closes the sample cycle.
                        if (end_scan) begin
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stop_pending <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            ch_id      <= nc_next;
                            s0         <= nc_next[0];
                            s1         <= nc_next[1];
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SETTLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                        // Raise the strobe on entry to the final dwell cycle.
                        sample_en <= (dwell_cnt == DWELL_W'(2));
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed and randomized bench for mux_sel_sequencer. The reference model
// builds the expected per-cycle trace from the scan rules: ascending list of
// enabled channels, a fixed period of settle+dwell cycles per channel, a
// sample on the last cycle of each period, and a termination point.
module tb_mux_sel_sequencer;

    localparam int DW       = 4;
    localparam int SETTLE_N = 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic          mode;
    logic [3:0]    ch_mask;
    logic [DW-1:0] dwell;
    logic          s0;
    logic          s1;
    logic          sample_en;
    logic [1:0]    ch_id;
    logic          busy;
    logic          done;

    int         n_cmp;
    int         n_bad;
    logic [1:0] model_ch;

    mux_sel_sequencer #(
        .DWELL_W       (DW),
        .SETTLE_CYCLES (SETTLE_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .s0        (s0),
        .s1        (s1),
        .sample_en (sample_en),
        .ch_id     (ch_id),
        .busy      (busy),
        .done      (done)
    );

    // Clock: rising edges at 5, 15, 25, ...; outputs sampled on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Time limit.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string ctx, input logic [1:0] e_ch, input logic e_se,
                             input logic e_busy, input logic e_done);
        check({ctx, ".ch_id"}, ch_id, e_ch);
        check({ctx, ".sel"}, {s1, s0}, e_ch);
        check({ctx, ".sample_en"}, {1'b0, sample_en}, {1'b0, e_se});
        check({ctx, ".busy"}, {1'b0, busy}, {1'b0, e_busy});
        check({ctx, ".done"}, {1'b0, done}, {1'b0, e_done});
    endtask

    // Asynchronous reset raised mid-cycle (called at a falling edge).
    task automatic async_reset(input int hold);
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b1;
        #1;
        check_out("rst_async", 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check_out("rst_hold", 2'd0, 1'b0, 1'b0, 1'b0);
        end
        #1 rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_out("rst_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        end
        model_ch = 2'd0;
    endtask

    // One scan, called at a falling edge. stop_c: cycle in which stop is
    // driven (0 = never). noise: 0 none, 1 mask=0001 and start held during
    // the scan, 2 random start/mask/dwell/mode during the scan. rst_c: cycle
    // in which reset is raised (0 = never). gap: idle cycles observed after.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] d, input logic md,
                            input int stop_c, input int noise, input int rst_c, input int gap);
        logic [1:0] chans[$];
        logic [1:0] end_ch;
        logic [1:0] e_ch;
        logic       e_se;
        logic       e_busy;
        logic       e_done;
        int         n;
        int         p;
        int         endc;
        int         nc;
        chans = {};
        for (int i = 0; i < 4; i++) begin
            if (m[i]) chans.push_back(2'(i));
        end
        n      = chans.size();
        p      = SETTLE_N + ((d == 0) ? 1 : int'(d));
        endc   = 0;
        end_ch = model_ch;
        if (n > 0) begin
            for (int j = 0; j < 1000; j++) begin
                int s;
                s = j * p + p;
                if ((stop_c > 0 && s >= stop_c) || (!md && (j % n) == n - 1)) begin
                    endc   = s;
                    end_ch = chans[j % n];
                    break;
                end
            end
        end
        nc = endc + 2 + gap;

        // Cycle 0: present the start request (a stop here must be ignored).
        start   = 1'b1;
        ch_mask = m;
        dwell   = d;
        mode    = md;
        stop    = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);

        for (int k = 1; k <= nc; k++) begin
            if (k <= endc) begin
                e_busy = 1'b1;
                e_done = 1'b0;
                e_ch   = chans[((k - 1) / p) % n];
                e_se   = ((k % p) == 0);
            end else begin
                e_busy = 1'b0;
                e_se   = 1'b0;
                e_done = (k == endc + 1);
                e_ch   = end_ch;
            end
            check_out($sformatf("scan m=%b d=%0d md=%0d k=%0d", m, d, md, k), e_ch, e_se, e_busy, e_done);

            if (k == rst_c) begin
                async_reset(1);
                return;
            end

            // Inputs for the edge that closes cycle k.
            start = 1'b0;
            stop  = 1'b0;
            if (k <= endc && noise == 1) begin
                start   = 1'b1;
                ch_mask = 4'b0001;
                dwell   = 4'd0;
                mode    = 1'b1;
            end else if (k <= endc && noise == 2) begin
                start   = 1'($urandom_range(0, 1));
                ch_mask = 4'($urandom_range(0, 15));
                dwell   = 4'($urandom_range(0, 15));
                mode    = 1'($urandom_range(0, 1));
            end
            if (k > endc) stop = 1'($urandom_range(0, 1));
            if (k == stop_c) stop = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        start    = 1'b0;
        stop     = 1'b0;
        model_ch = end_ch;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        model_ch = 2'd0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        ch_mask  = 4'd0;
        dwell    = '0;

        // Reset values before any clock edge.
        #2;
        check_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("post_reset", 2'd0, 1'b0, 1'b0, 1'b0);

        // Short asynchronous reset pulse between clock edges.
        async_reset(0);

        // Full single sweep: samples at cycles 3,6,9,12, done at 13.
        run_scan(4'b1111, 4'd2, 1'b0, 0, 0, 0, 2);

        // Continuous on channels 1 and 3, zero dwell, stop in ch 3's second settle.
        run_scan(4'b1010, 4'd0, 1'b1, 7, 0, 0, 2);

        // Empty mask: done only.
        run_scan(4'b0000, 4'd5, 1'b0, 0, 0, 0, 2);

        // Mask/start/dwell/mode churn while busy must be ignored.
        run_scan(4'b1111, 4'd3, 1'b0, 0, 1, 0, 1);

        // Reset during the dwell of channel 2, then a clean restart.
        run_scan(4'b0111, 4'd4, 1'b0, 0, 0, 13, 0);
        run_scan(4'b0111, 4'd1, 1'b0, 0, 0, 0, 1);

        // Single enabled channel, continuous: resampled until stop.
        run_scan(4'b0100, 4'd2, 1'b1, 8, 0, 0, 1);
        // Single enabled channel, single sweep.
        run_scan(4'b1000, 4'd15, 1'b0, 0, 0, 0, 1);

        // Randomized scans.
        for (int it = 0; it < 30; it++) begin
            logic [3:0] m;
            logic [3:0] d;
            logic       md;
            int         n_en;
            int         p;
            int         sc;
            int         rc;
            m    = 4'($urandom_range(0, 15));
            d    = 4'($urandom_range(0, 15));
            md   = 1'($urandom_range(0, 1));
            n_en = $countones(m);
            p    = SETTLE_N + ((d == 0) ? 1 : int'(d));
            if (md || ($urandom_range(0, 1) == 1))
                sc = $urandom_range(1, 2 * ((n_en > 0) ? n_en : 1) * p);
            else
                sc = 0;
            if (m != 0 && $urandom_range(0, 7) == 0)
                rc = $urandom_range(1, p);
            else
                rc = 0;
            run_scan(m, d, md, sc, $urandom_range(0, 2), rc, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
